counter8_driver: RTL and testbench

- Command-side master for the counter8 block. It generates the load/inc/data stream that the counter's next-state logic consumes.
- On a start request it loads a start value, issues a programmed number of up- or down-count cycles, then parks the counter at the final value.
- It tracks the counter's expected value internally. With the optional feature enabled, it checks that expected value against the counter's actual output.
- Used by the top level and benches as the single source of counter commands.

---
 rtl/counter8_driver.sv | 141 ++++++++++++++
 tb/tb_counter8_driver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/counter8_driver.sv
// Command-side master for counter8: load a start value, count up/down for a
// programmed number of cycles, then park. Optional checker: COUNTER8_DRIVER_CHECK_EN.
module counter8_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] steps,
`ifdef COUNTER8_DRIVER_CHECK_EN
    input  logic [WIDTH-1:0] cnt_q,
    output logic             err,
`endif
    output logic             load,
    output logic             inc,
    output logic [WIDTH-1:0] d_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] exp_q
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] RUN  = 2'b10;
    localparam logic [1:0] DONE = 2'b11;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] exp_q_reg, exp_q_next;
    logic [WIDTH-1:0] remaining_reg, remaining_next;
    logic [WIDTH-1:0] din_l_reg, din_l_next;
    logic [WIDTH-1:0] steps_l_reg, steps_l_next;
    logic             dir_l_reg, dir_l_next;

    logic             load_reg, load_next;
    logic             inc_reg, inc_next;
    logic [WIDTH-1:0] d_out_reg, d_out_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    always_comb begin
        state_next     = state_reg;
        exp_q_next     = exp_q_reg;
        remaining_next = remaining_reg;
        din_l_next     = din_l_reg;
        steps_l_next   = steps_l_reg;
        dir_l_next     = dir_l_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    din_l_next   = din;
                    steps_l_next = steps;
                    dir_l_next   = dir;
                    state_next   = LOAD;
                end
            end
            LOAD: begin
                exp_q_next     = din_l_reg;
                remaining_next = steps_l_reg;
                state_next     = (steps_l_reg != '0) ? RUN : DONE;
            end
            RUN: begin
                exp_q_next     = dir_l_reg ? exp_q_reg + WIDTH'(1) : exp_q_reg - WIDTH'(1);
                remaining_next = remaining_reg - WIDTH'(1);
                if (remaining_reg == WIDTH'(1)) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are precomputed from the next state so they are plain flops that
    // show exactly what the current state demands of the counter.
    always_comb begin
        load_next  = (state_next != RUN);
        inc_next   = (state_next == RUN) && dir_l_next;
        d_out_next = (state_next == LOAD) ? din_l_next : exp_q_next;
        busy_next  = (state_next == LOAD) || (state_next == RUN);
        done_next  = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            exp_q_reg     <= '0;
            remaining_reg <= '0;
            din_l_reg     <= '0;
            steps_l_reg   <= '0;
            dir_l_reg     <= 1'b0;
            load_reg      <= 1'b1;
            inc_reg       <= 1'b0;
            d_out_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            exp_q_reg     <= exp_q_next;
            remaining_reg <= remaining_next;
            din_l_reg     <= din_l_next;
            steps_l_reg   <= steps_l_next;
            dir_l_reg     <= dir_l_next;
            load_reg      <= load_next;
            inc_reg       <= inc_next;
            d_out_reg     <= d_out_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign load  = load_reg;
    assign inc   = inc_reg;
    assign d_out = d_out_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign exp_q = exp_q_reg;

`ifdef COUNTER8_DRIVER_CHECK_EN
    // The counter updates on the same edge as exp_q, so both are compared as-is.
    logic arm_reg;
    logic err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            arm_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            arm_reg <= 1'b1;
            if (arm_reg && (cnt_q != exp_q_reg)) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err = err_reg;
`endif

endmodule

// File: tb/tb_counter8_driver.sv
// Self-checking bench for counter8_driver: per-cycle vector table plus
// hand sequences for mid-command reset, wrap-around and the optional checker.
module tb_counter8_driver;

    logic       clk = 1'b0;
    logic       reset, start, dir;
    logic [7:0] din, steps;
    logic       load, inc, busy, done;
    logic [7:0] d_out, exp_q;
`ifdef COUNTER8_DRIVER_CHECK_EN
    logic [7:0] cnt_model, cnt_q;
    logic       err, force_en;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    counter8_driver #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .dir   (dir),
        .din   (din),
        .steps (steps),
`ifdef COUNTER8_DRIVER_CHECK_EN
        .cnt_q (cnt_q),
        .err   (err),
`endif
        .load  (load),
        .inc   (inc),
        .d_out (d_out),
        .busy  (busy),
        .done  (done),
        .exp_q (exp_q)
    );

`ifdef COUNTER8_DRIVER_CHECK_EN
    // Behavioural counter8 that obeys the driver's commands.
    always @(posedge clk) begin
        if (reset)      cnt_model <= 8'h00;
        else if (load)  cnt_model <= d_out;
        else if (inc)   cnt_model <= cnt_model + 8'h01;
        else            cnt_model <= cnt_model - 8'h01;
    end
    assign cnt_q = force_en ? 8'h00 : cnt_model;
`endif

    typedef struct {
        logic       rst, st, dr;
        logic [7:0] dn, stp;
        logic       e_load, e_inc, e_busy, e_done;
        logic [7:0] e_d, e_q;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic dr,
                        input logic [7:0] dn, input logic [7:0] st);
        @(negedge clk);
        reset = r; start = s; dir = dr; din = dn; steps = st;
        @(posedge clk);
        #1;
    endtask

    // d_out is only meaningful while load is expected high.
    task automatic chk_all(input string tag, input logic e_load, input logic e_inc,
                           input logic e_busy, input logic e_done,
                           input logic [7:0] e_d, input logic [7:0] e_q);
        $display("%s: load=%0b inc=%0b busy=%0b done=%0b d_out=%02h exp_q=%02h",
                 tag, load, inc, busy, done, d_out, exp_q);
        chk({tag, ".load"}, 32'(load), 32'(e_load));
        if (!e_load) chk({tag, ".inc"}, 32'(inc), 32'(e_inc));
        chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
        chk({tag, ".done"}, 32'(done), 32'(e_done));
        if (e_load) chk({tag, ".d_out"}, 32'(d_out), 32'(e_d));
        chk({tag, ".exp_q"}, 32'(exp_q), 32'(e_q));
    endtask

    initial begin
        int n_done;
        int n_run;
        reset = 1'b1; start = 1'b0; dir = 1'b0; din = 8'h00; steps = 8'h00;
`ifdef COUNTER8_DRIVER_CHECK_EN
        force_en = 1'b0;
`endif
        //            rst  st   dr   din    steps  load inc  busy done d_out  exp_q
        tbl[0]  = '{1'b1,1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h00,8'h00};
        tbl[1]  = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h00,8'h00};
        tbl[2]  = tbl[1];
        tbl[3]  = tbl[1];
        tbl[4]  = tbl[1];
        tbl[5]  = tbl[1];
        tbl[6]  = '{1'b0,1'b1,1'b1,8'h10,8'h03, 1'b1,1'b0,1'b1,1'b0,8'h10,8'h00};
        tbl[7]  = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b1,1'b1,1'b0,8'h00,8'h10};
        tbl[8]  = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,1'b1,1'b1,1'b0,8'h00,8'h11};
        tbl[9]  = '{1'b0,1'b1,1'b0,8'h55,8'h07, 1'b0,1'b1,1'b1,1'b0,8'h00,8'h12};
        tbl[10] = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b1,8'h13,8'h13};
        tbl[11] = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0,8'h13,8'h13};
        tbl[12] = '{1'b0,1'b1,1'b0,8'h01,8'h02, 1'b1,1'b0,1'b1,1'b0,8'h01,8'h13};
        tbl[13] = '{1'b0,1'b1,1'b1,8'h77,8'h09, 1'b0,1'b0,1'b1,1'b0,8'h00,8'h01};
        tbl[14] = '{1'b0,1'b1,1'b1,8'h77,8'h09, 1'b0,1'b0,1'b1,1'b0,8'h00,8'h00};
        tbl[15] = '{1'b0,1'b1,1'b1,8'h77,8'h09, 1'b1,1'b0,1'b0,1'b1,8'hFF,8'hFF};
        tbl[16] = '{1'b0,1'b1,1'b1,8'h77,8'h09, 1'b1,1'b0,1'b0,1'b0,8'hFF,8'hFF};
        tbl[17] = '{1'b0,1'b1,1'b1,8'hA5,8'h00, 1'b1,1'b0,1'b1,1'b0,8'hA5,8'hFF};
        tbl[18] = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b1,8'hA5,8'hA5};
        tbl[19] = '{1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,1'b0,1'b0,8'hA5,8'hA5};

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].rst, tbl[i].st, tbl[i].dr, tbl[i].dn, tbl[i].stp);
            chk_all($sformatf("vec%0d", i), tbl[i].e_load, tbl[i].e_inc, tbl[i].e_busy,
                    tbl[i].e_done, tbl[i].e_d, tbl[i].e_q);
        end

        // Reset in the 2nd RUN cycle while start is held high throughout.
        step(1'b0, 1'b1, 1'b1, 8'h40, 8'h05);
        chk_all("midrst.load", 1'b1, 1'b0, 1'b1, 1'b0, 8'h40, 8'hA5);
        step(1'b0, 1'b1, 1'b0, 8'h99, 8'h01);
        chk_all("midrst.run1", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h40);
        step(1'b0, 1'b1, 1'b0, 8'h99, 8'h01);
        chk_all("midrst.run2", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h41);
        step(1'b1, 1'b1, 1'b0, 8'h99, 8'h01);
        chk_all("midrst.reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            chk_all($sformatf("midrst.idle%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        end

        // Full-range wrap: 01 + 255 up-counts ends at 00, done in cycle steps+2.
        step(1'b0, 1'b1, 1'b1, 8'h01, 8'hFF);
        $display("wrap.start: load=%0b busy=%0b d_out=%02h", load, busy, d_out);
        n_done = -1;
        n_run = 0;
        for (int c = 2; c <= 300; c++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            if (!load) n_run++;
            if (done) begin
                n_done = c;
                break;
            end
        end
        $display("wrap.done: cycle=%0d run_cycles=%0d d_out=%02h exp_q=%02h",
                 n_done, n_run, d_out, exp_q);
        chk("wrap.done_cycle", 32'(n_done), 32'd257);
        chk("wrap.run_cycles", 32'(n_run), 32'd255);
        chk("wrap.exp_q", 32'(exp_q), 32'h00);
        chk("wrap.d_out", 32'(d_out), 32'h00);

`ifdef COUNTER8_DRIVER_CHECK_EN
        chk("chk.err_clean", 32'(err), 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'h13, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("chk.idle_q", 32'(exp_q), 32'h13);
        chk("chk.err_before", 32'(err), 32'd0);
        @(negedge clk);
        force_en = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        force_en = 1'b0;
        $display("chk.force: err=%0b", err);
        chk("chk.err_set", 32'(err), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
            chk($sformatf("chk.err_sticky%0d", i), 32'(err), 32'd1);
        end
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        $display("chk.reset: err=%0b", err);
        chk("chk.err_cleared", 32'(err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
